// File: rtl/subleq_ctrl_if.sv
// RAM-side bus of the subleq machine: controller is master, RAM/top level is slave.
interface subleq_ctrl_if;
    logic       ram_ctl;    // 1 = read, 0 = write
    logic       ram_ena;
    logic [7:0] ram_adr;
    logic [7:0] ram_wdata;
    logic       ram_wdrv;   // top level drives ram_wdata onto the data bus
    logic [7:0] ram_rdata;

    modport master (
        output ram_ctl, ram_ena, ram_adr, ram_wdata, ram_wdrv,
        input  ram_rdata
    );

    modport slave (
        input  ram_ctl, ram_ena, ram_adr, ram_wdata, ram_wdrv,
        output ram_rdata
    );
endinterface

// File: rtl/subleq_ctrl.sv
// Subleq sequencer: fetch A,B,C, read mem[A], mem[B], write mem[B]-mem[A],
// branch to C on a result <= 0 (signed), halt on a taken branch to HALT_ADDR.
module subleq_ctrl #(
    parameter logic [7:0] HALT_ADDR = 8'hFF,
    parameter logic [7:0] START_PC  = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [7:0]         start_pc_i,
    subleq_ctrl_if.master      ram,
    output logic [7:0]         pc_o,
    output logic               busy_o,
    output logic               halted_o,
    output logic [15:0]        icount_o
);

    typedef enum logic [2:0] {IDLE, FA, FB, FC, RA, RB, WR, HALT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic [7:0]  va_q, va_d, vb_q, vb_d;
    logic [15:0] icount_q, icount_d;
    logic        ctl_q, ctl_d, ena_q, ena_d, wdrv_q, wdrv_d;
    logic [7:0]  adr_q, adr_d, wdata_q, wdata_d;
    logic [7:0]  res;
    logic        leq;

    assign res = vb_q - va_q;
    assign leq = res[7] | (res == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: fixed FA..WR walk, start only honoured from IDLE/HALT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALT: if (start_i) state_d = FA;
            FA:         state_d = FB;
            FB:         state_d = FC;
            FC:         state_d = RA;
            RA:         state_d = RB;
            RB:         state_d = WR;
            WR:         state_d = (leq && (c_q == HALT_ADDR)) ? HALT : FA;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath next values: capture read data at the end of each read state
    always_comb begin
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        va_d     = va_q;
        vb_d     = vb_q;
        icount_d = icount_q;
        case (state_q)
            IDLE, HALT: if (start_i) pc_d = start_pc_i;
            FA:         a_d  = ram.ram_rdata;
            FB:         b_d  = ram.ram_rdata;
            FC:         c_d  = ram.ram_rdata;
            RA:         va_d = ram.ram_rdata;
            RB:         vb_d = ram.ram_rdata;
            WR: begin
                icount_d = icount_q + 16'd1;
                // a halting branch has c == HALT_ADDR, so c_q covers both taken cases
                pc_d     = leq ? c_q : pc_q + 8'd3;
            end
            default: ;
        endcase
    end

    // Outputs: RAM pins are precomputed from the upcoming state so they come
    // straight from flops; the write data uses the operand arriving this cycle.
    always_comb begin
        ctl_d    = 1'b1;
        ena_d    = 1'b0;
        adr_d    = '0;
        wdata_d  = '0;
        wdrv_d   = 1'b0;
        busy_o   = (state_q != IDLE) && (state_q != HALT);
        halted_o = (state_q == HALT);
        case (state_d)
            FA: begin ena_d = 1'b1; adr_d = pc_d;          end
            FB: begin ena_d = 1'b1; adr_d = pc_q + 8'd1;   end
            FC: begin ena_d = 1'b1; adr_d = pc_q + 8'd2;   end
            RA: begin ena_d = 1'b1; adr_d = a_q;           end
            RB: begin ena_d = 1'b1; adr_d = b_q;           end
            WR: begin
                ctl_d   = 1'b0;
                ena_d   = 1'b1;
                adr_d   = b_q;
                wdata_d = ram.ram_rdata - va_q;
                wdrv_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and RAM pin registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= START_PC;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            va_q     <= '0;
            vb_q     <= '0;
            icount_q <= '0;
            ctl_q    <= 1'b1;
            ena_q    <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            wdrv_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            va_q     <= va_d;
            vb_q     <= vb_d;
            icount_q <= icount_d;
            ctl_q    <= ctl_d;
            ena_q    <= ena_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            wdrv_q   <= wdrv_d;
        end
    end

    assign ram.ram_ctl   = ctl_q;
    assign ram.ram_ena   = ena_q;
    assign ram.ram_adr   = adr_q;
    assign ram.ram_wdata = wdata_q;
    assign ram.ram_wdrv  = wdrv_q;
    assign pc_o          = pc_q;
    assign icount_o      = icount_q;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Directed bench for subleq_ctrl with a behavioural 256-byte RAM.
module tb_subleq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  start_pc;
    logic [7:0]  pc;
    logic        busy, halted;
    logic [15:0] icount;

    logic        ld_en = 1'b0;
    logic [7:0]  ld_adr = '0, ld_dat = '0;
    logic [7:0]  mem [256];

    int n_pass  = 0;
    int n_total = 0;

    subleq_ctrl_if bus();

    subleq_ctrl #(.HALT_ADDR(8'hFF), .START_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .start_pc_i (start_pc),
        .ram        (bus),
        .pc_o       (pc),
        .busy_o     (busy),
        .halted_o   (halted),
        .icount_o   (icount)
    );

    always #5 clk = ~clk;

    // Combinational-read RAM; preload port shares the single write process
    assign bus.ram_rdata = mem[bus.ram_adr];
    always @(posedge clk) begin
        if (ld_en)
            mem[ld_adr] <= ld_dat;
        else if (bus.ram_ena && !bus.ram_ctl && bus.ram_wdrv)
            mem[bus.ram_adr] <= bus.ram_wdata;
    end

    typedef struct {
        logic [7:0] sp, a, b, c, va, vb;
        logic [7:0] w, npc;
        logic       halt;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic load(input logic [7:0] adr, input logic [7:0] dat);
        ld_adr = adr;
        ld_dat = dat;
        ld_en  = 1'b1;
        @(negedge clk);
        ld_en  = 1'b0;
    endtask

    task automatic prep(input vec_t v);
        rst = 1'b1;
        @(negedge clk);
        load(v.sp, v.a);
        load(v.sp + 8'd1, v.b);
        load(v.sp + 8'd2, v.c);
        load(v.a, v.va);
        load(v.b, v.vb);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One instruction: per-cycle bus check, then architectural state after WR
    task automatic run_vec(input vec_t v, input int pulse_k, input string tag);
        logic [7:0]  eadr [6];
        logic [10:0] ebus;
        prep(v);
        eadr[0] = v.sp;
        eadr[1] = v.sp + 8'd1;
        eadr[2] = v.sp + 8'd2;
        eadr[3] = v.a;
        eadr[4] = v.b;
        eadr[5] = v.b;
        start_pc = v.sp;
        start    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == pulse_k) start = 1'b1;
            if (k == pulse_k + 1) start = 1'b0;
            ebus = {1'b1, (k != 5), (k == 5), eadr[k]};
            chk($sformatf("%s bus c%0d", tag, k),
                {bus.ram_ena, bus.ram_ctl, bus.ram_wdrv, bus.ram_adr}, ebus);
            if (k == 5) chk({tag, " wdata"}, bus.ram_wdata, v.w);
        end
        start = 1'b0;
        @(negedge clk);
        chk({tag, " pc"}, pc, v.npc);
        chk({tag, " icount"}, icount, 16'd1);
        chk({tag, " halted/busy/ena"}, {halted, busy, bus.ram_ena},
            {v.halt, !v.halt, !v.halt});
        chk({tag, " mem[b]"}, mem[v.b], v.w);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ram pins"},
            {bus.ram_ena, bus.ram_ctl, bus.ram_wdrv, bus.ram_adr, bus.ram_wdata},
            {1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
        chk({tag, " pc/busy/halted/icount"}, {pc, busy, halted, icount},
            {8'h00, 1'b0, 1'b0, 16'h0000});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        //          sp     a      b      c      va     vb     w      npc    halt
        vecs[0] = '{8'h00, 8'h0A, 8'h0B, 8'h06, 8'h03, 8'h05, 8'h02, 8'h03, 1'b0};
        vecs[1] = '{8'h00, 8'h0A, 8'h0B, 8'h06, 8'h03, 8'h03, 8'h00, 8'h06, 1'b0};
        vecs[2] = '{8'h00, 8'h0A, 8'h0B, 8'h06, 8'h03, 8'h02, 8'hFF, 8'h06, 1'b0};
        vecs[3] = '{8'h00, 8'h0A, 8'h0B, 8'hFF, 8'h04, 8'h04, 8'h00, 8'hFF, 1'b1};
        vecs[4] = '{8'hFE, 8'h0A, 8'h0B, 8'h06, 8'h01, 8'h05, 8'h04, 8'h01, 1'b0};
        vecs[5] = '{8'h00, 8'h20, 8'h20, 8'h40, 8'h07, 8'h07, 8'h00, 8'h40, 1'b0};
        vecs[6] = '{8'h00, 8'h0A, 8'h0B, 8'h50, 8'h80, 8'h7F, 8'hFF, 8'h50, 1'b0};
        vecs[7] = '{8'h00, 8'h0A, 8'h0B, 8'h50, 8'h01, 8'h80, 8'h7F, 8'h03, 1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        start_pc = 8'h00;
        #1;
        chk_reset_vals("por");
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], -1, $sformatf("vec%0d", i));

        // start during RB is ignored
        run_vec(vecs[0], 4, "start_in_rb");

        // restart from HALT: left halted by the halting program, program still at 0
        run_vec(vecs[3], -1, "halt_again");
        start_pc = 8'h00;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        chk("restart halted/busy/ena", {halted, busy, bus.ram_ena}, 3'b011);
        chk("restart adr", bus.ram_adr, 8'h00);

        // async reset during WR: pins drop with no clock edge, no write, icount stays 0
        prep(vecs[0]);
        start_pc = 8'h00;
        start    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre-rst wr wdrv", bus.ram_wdrv, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk_reset_vals("rst_in_wr");
        @(negedge clk);
        chk("rst_in_wr mem[b] untouched", mem[8'h0B], 8'h05);

        // async reset during FB with pc = FE returns pc to START_PC
        prep(vecs[4]);
        start_pc = 8'hFE;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        @(negedge clk);
        chk("pre-rst fb adr", bus.ram_adr, 8'hFF);
        #1 rst = 1'b1;
        #1;
        chk_reset_vals("rst_in_fb");
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/subleq_ctrl.md
Name: subleq_ctrl

Overview:
Sequencer for the subleq machine. It fetches three-byte instructions (A, B, C) from the shared 8-bit RAM, reads both operands, and writes mem[B]-mem[A] back to mem[B]. It branches to C when the result is ≤0 (signed), otherwise advances PC by 3. It is the only master of the RAM's ctl/ena/adr/dat pins; the top level builds the tristate data bus from ram_wdata/ram_wdrv.

Parameters:
HALT_ADDR, 8'hFF, a taken branch to this address stops the machine instead of jumping
START_PC, 8'h00, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  single-cycle pulse; loads pc from start_pc and begins execution
start_pc  input  8  entry address sampled with start
ram_ctl  output  1  RAM ctl: 1 = read, 0 = write
ram_ena  output  1  RAM enable
ram_adr  output  8  RAM address
ram_wdata  output  8  write data for the RAM data bus
ram_wdrv  output  1  1 = top level drives ram_wdata onto the RAM data bus
ram_rdata  input  8  RAM data bus as read back
pc  output  8  current program counter
busy  output  1  executing an instruction
halted  output  1  stopped on a taken branch to HALT_ADDR
icount  output  16  completed-instruction counter, wraps mod 2^16

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, pc=START_PC, ram_ena=0, ram_ctl=1, ram_adr=0, ram_wdata=0, ram_wdrv=0.
  - busy=0, halted=0, icount=0, internal regs a/b/c/va/vb=0.
- All RAM-side outputs are flops, so they are stable for the whole cycle of their state. The RAM read is combinational, and ram_rdata is captured at the rising edge that ends each read state.
- States (one cycle each unless noted):
  - IDLE: ena=0. On start, pc<=start_pc, halted<=0, go to FA. Otherwise stay.
  - FA: read adr=pc; capture a. Go to FB.
  - FB: read adr=pc+1 (mod 256); capture b. Go to FC.
  - FC: read adr=pc+2 (mod 256); capture c. Go to RA.
  - RA: read adr=a; capture va. Go to RB.
  - RB: read adr=b; capture vb. Go to WR.
  - WR: ctl=0, ena=1, adr=b, wdata=vb-va (8-bit wrap), wdrv=1.
    - At the end of the cycle: r=vb-va; leq = r[7] | (r==0); icount++.
    - If leq and c==HALT_ADDR: pc<=HALT_ADDR, go to HALT.
    - Else if leq: pc<=c. Else: pc<=pc+3 (mod 256).
    - Next state FA.
  - HALT: ena=0, halted=1. On start, behave as in IDLE (restart).
- Fixed 6 cycles per instruction, FA through WR. busy=1 in FA..WR.
- ram_wdrv=1 and ram_ctl=0 only in WR, and never both with ram_ena=0.
- Self-modifying code: a write to an instruction byte is visible to the next fetch; no caching.
- start while busy is ignored. start coincident with rst is ignored (reset wins).
- rst mid-instruction, including during WR: all outputs return to reset values immediately, asynchronously. No further RAM access occurs. A partial write is the RAM's concern; the controller guarantees ena deasserts at once.
- Operand addresses a, b may equal pc..pc+2 or each other; no special casing. a==b gives r=0, so the branch is taken.
- pc, pc+1, pc+2 and pc+3 all wrap mod 256.

Test Plan:
1. Assert rst mid-run -> all outputs at reset values with no clock edge; pc=START_PC, ram_ena=0, ram_wdrv=0.
2. mem[0..2]={10,11,6}, mem[10]=3, mem[11]=5; start with start_pc=0 -> bus sequence:
   - reads 0, 1, 2, 10, 11, then a write of 2 to 11;
   - 6 cycles, pc=3, icount=1.
3. Same program with mem[11]=3 -> writes 0, pc=6. With mem[11]=2 -> writes 8'hFF (−1), pc=6.
4. mem[0..2]={10,11,FF} with mem[11]=mem[10]=4 -> writes 0, then halted=1, busy=0, pc=FF, ram_ena=0. A following start with start_pc=0 -> halted=0 and execution restarts at address 0.
5. start_pc=FE -> instruction fetch addresses FE, FF, 00. The not-taken result gives pc=01.
6. Pulse start during RB -> ignored, instruction completes normally. Assert rst during WR -> ena/wdrv drop asynchronously and icount is unchanged (0).
